// File: rtl/png_pkg.sv
// Shared definitions for the PNG IDAT path.
// Holds the zlib header constants, byte and word widths, the zlib_wrap
// state encoding, and a helper that picks one Adler-32 byte, MSB first.
package png_pkg;

    localparam int BYTE_WD    = 8;
    localparam int ADLER32_WD = 32;

    // CM=8 (deflate), CINFO=7 (32K window); FLG chosen so the 16-bit
    // header is a multiple of 31 with no preset dictionary.
    localparam logic [BYTE_WD-1:0] ZLIB_CMF = 8'h78;
    localparam logic [BYTE_WD-1:0] ZLIB_FLG = 8'h01;

    typedef enum logic [2:0] {
        ZW_IDLE = 3'd0,
        ZW_HDR0 = 3'd1,
        ZW_HDR1 = 3'd2,
        ZW_DATA = 3'd3,
        ZW_WADL = 3'd4,
        ZW_TRL  = 3'd5,
        ZW_FIN  = 3'd6
    } zw_state_e;

    // Byte idx of an Adler-32 word, idx 0 being the most significant byte.
    function automatic logic [BYTE_WD-1:0] adler_byte(
        input logic [ADLER32_WD-1:0] word,
        input logic [1:0]            idx
    );
        logic [BYTE_WD-1:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_oreg.sv
// Single-stage valid/ready output register for an 8-bit byte plus a
// last flag.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_val/in_dat/in_lst  byte offered by the producer this cycle
//   ld                 register can take a new byte this cycle
//   out_val/out_dat/out_lst  registered byte towards the consumer
//   out_rdy            consumer accepts out_* this cycle
// Valid/ready: a byte moves on a rising edge where valid and ready are
// both high; while valid is high and ready is low, dat/lst/val hold.
module byte_oreg
    import png_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_val,
    input  logic [BYTE_WD-1:0] in_dat,
    input  logic               in_lst,
    output logic               ld,
    output logic               out_val,
    output logic [BYTE_WD-1:0] out_dat,
    output logic               out_lst,
    input  logic               out_rdy
);

    // The register may reload when it is empty or its byte leaves now.
    assign ld = !out_val || out_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_val <= 1'b0;
            out_dat <= '0;
            out_lst <= 1'b0;
        end else if (ld) begin
            out_val <= in_val;
            out_lst <= in_val && in_lst;
            if (in_val) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/zlib_wrap.sv
// Wraps a raw deflate byte stream in a zlib container: CMF, FLG, the
// deflate bytes unchanged, then the Adler-32 checksum MSB first.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   start_i                    frame start, taken only when idle
//   din_val_i/din_rdy_o/din_dat_i/din_lst_i  deflate byte input
//   adl_val_i/adl_dat_i        Adler-32 result {s2,s1}, pulse or held
//   dout_val_o/dout_rdy_i/dout_dat_o/dout_lst_o  registered zlib bytes
//   done_o                     one-cycle pulse after the last byte leaves
// Valid/ready: a byte moves on a rising edge where valid and ready are
// both high; while dout_val_o is high and dout_rdy_i is low, dout_* hold.
module zlib_wrap
    import png_pkg::*;
#(
    parameter logic [BYTE_WD-1:0] CMF = ZLIB_CMF,
    parameter logic [BYTE_WD-1:0] FLG = ZLIB_FLG
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  din_val_i,
    output logic                  din_rdy_o,
    input  logic [BYTE_WD-1:0]    din_dat_i,
    input  logic                  din_lst_i,
    input  logic                  adl_val_i,
    input  logic [ADLER32_WD-1:0] adl_dat_i,
    output logic                  dout_val_o,
    input  logic                  dout_rdy_i,
    output logic [BYTE_WD-1:0]    dout_dat_o,
    output logic                  dout_lst_o,
    output logic                  done_o
);

    // The zlib header check bits require (CMF*256 + FLG) mod 31 == 0.
    if (((int'(CMF) * 256) + int'(FLG)) % 31 != 0) begin : g_bad_fcheck
        $error("zlib_wrap: CMF/FLG pair fails the zlib header check");
    end

    zw_state_e             state, state_nxt;
    logic [1:0]            cnt, cnt_nxt;
    logic [ADLER32_WD-1:0] adl_lat_r;
    logic                  adl_hit_r;
    logic                  done_nxt;

    logic                  ld;
    logic                  push_val;
    logic [BYTE_WD-1:0]    push_dat;
    logic                  push_lst;

    byte_oreg u_oreg (
        .clk     (clk),
        .rstn    (rstn),
        .in_val  (push_val),
        .in_dat  (push_dat),
        .in_lst  (push_lst),
        .ld      (ld),
        .out_val (dout_val_o),
        .out_dat (dout_dat_o),
        .out_lst (dout_lst_o),
        .out_rdy (dout_rdy_i)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ZW_IDLE;
            cnt    <= 2'd0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_o <= done_nxt;
        end
    end

    // First Adler value of a frame wins; the latch is re-armed in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            adl_lat_r <= '0;
            adl_hit_r <= 1'b0;
        end else if (state == ZW_IDLE) begin
            adl_hit_r <= 1'b0;
        end else if (adl_val_i && !adl_hit_r) begin
            adl_lat_r <= adl_dat_i;
            adl_hit_r <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        push_val  = 1'b0;
        push_dat  = '0;
        push_lst  = 1'b0;
        din_rdy_o = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ZW_IDLE: begin
                if (start_i) state_nxt = ZW_HDR0;
            end
            ZW_HDR0: begin
                if (ld) begin
                    push_val  = 1'b1;
                    push_dat  = CMF;
                    state_nxt = ZW_HDR1;
                end
            end
            ZW_HDR1: begin
                if (ld) begin
                    push_val  = 1'b1;
                    push_dat  = FLG;
                    state_nxt = ZW_DATA;
                end
            end
            ZW_DATA: begin
                din_rdy_o = ld;
                if (din_val_i && ld) begin
                    push_val = 1'b1;
                    push_dat = din_dat_i;
                    if (din_lst_i) state_nxt = ZW_WADL;
                end
            end
            ZW_WADL: begin
                // adl_val_i this cycle is latched on the same edge, so
                // TRL can read adl_lat_r without an extra wait state.
                if (adl_hit_r || adl_val_i) begin
                    cnt_nxt   = 2'd0;
                    state_nxt = ZW_TRL;
                end
            end
            ZW_TRL: begin
                if (ld) begin
                    push_val = 1'b1;
                    push_dat = adler_byte(adl_lat_r, cnt);
                    push_lst = (cnt == 2'd3);
                    cnt_nxt  = cnt + 2'd1;
                    if (cnt == 2'd3) state_nxt = ZW_FIN;
                end
            end
            ZW_FIN: begin
                if (dout_val_o && dout_rdy_i) begin
                    done_nxt  = 1'b1;
                    state_nxt = ZW_IDLE;
                end
            end
            default: state_nxt = ZW_IDLE;
        endcase
    end

endmodule

// File: tb/tb_zlib_wrap.sv
// Bench for zlib_wrap: random deflate payloads, Adler timing and output
// backpressure, checked against a byte-queue model of the zlib stream.
module tb_zlib_wrap;
    import png_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic        din_val_i = 1'b0;
    logic        din_rdy_o;
    logic [7:0]  din_dat_i = 8'h00;
    logic        din_lst_i = 1'b0;
    logic        adl_val_i = 1'b0;
    logic [31:0] adl_dat_i = 32'h0;
    logic        dout_val_o;
    logic        dout_rdy_i = 1'b1;
    logic [7:0]  dout_dat_o;
    logic        dout_lst_o;
    logic        done_o;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    zlib_wrap dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .din_val_i  (din_val_i),
        .din_rdy_o  (din_rdy_o),
        .din_dat_i  (din_dat_i),
        .din_lst_i  (din_lst_i),
        .adl_val_i  (adl_val_i),
        .adl_dat_i  (adl_dat_i),
        .dout_val_o (dout_val_o),
        .dout_rdy_i (dout_rdy_i),
        .dout_dat_o (dout_dat_o),
        .dout_lst_o (dout_lst_o),
        .done_o     (done_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];          // {lst, byte} of the expected zlib stream
    logic [7:0] log_q[$];          // bytes accepted downstream this frame
    int         log_cyc[$];
    int         rdy_pct = 100;
    bit         frame_open = 1'b0;
    bit         last_din_taken = 1'b0;
    int         out_cnt = 0;
    int         adl_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected zlib stream for one frame: header, payload, Adler MSB first.
    function automatic void model_frame(input logic [7:0] pay[$], input logic [31:0] adl);
        exp_q.push_back({1'b0, ZLIB_CMF});
        exp_q.push_back({1'b0, ZLIB_FLG});
        foreach (pay[i]) exp_q.push_back({1'b0, pay[i]});
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, adl[31 - 8*k -: 8]});
    endfunction

    // ---------------- compare process ----------------
    logic       p_val = 1'b0, p_rdy = 1'b0, p_lst = 1'b0;
    logic [7:0] p_dat = 8'h00;
    bit         exp_done = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_dout_val", dout_val_o, 0);
            check("rst_dout_dat", dout_dat_o, 0);
            check("rst_dout_lst", dout_lst_o, 0);
            check("rst_done", done_o, 0);
            check("rst_din_rdy", din_rdy_o, 0);
            exp_q.delete();
            exp_done = 1'b0;
            p_val = 1'b0;
            frame_open = 1'b0;
            last_din_taken = 1'b0;
        end else begin
            check("done_o", done_o, exp_done);
            exp_done = 1'b0;
            if (p_val && !p_rdy) begin
                check("stall_val", dout_val_o, 1);
                check("stall_dat", dout_dat_o, p_dat);
                check("stall_lst", dout_lst_o, p_lst);
            end
            // Deflate bytes may only be taken after CMF left, before the
            // frame's last deflate byte, and when the output can load.
            if (din_rdy_o)
                check("din_rdy_legal",
                      frame_open && out_cnt >= 1 && !last_din_taken && (!dout_val_o || dout_rdy_i), 1);
            if (dout_val_o && dout_rdy_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_dout_byte");
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("dout_dat", dout_dat_o, e[7:0]);
                    check("dout_lst", dout_lst_o, e[8]);
                    if (e[8]) begin
                        exp_done = 1'b1;
                        frame_open = 1'b0;
                    end
                end
                log_q.push_back(dout_dat_o);
                log_cyc.push_back(cyc);
                out_cnt++;
            end
            if (din_val_i && din_rdy_o && din_lst_i) last_din_taken = 1'b1;
            p_val = dout_val_o;
            p_rdy = dout_rdy_i;
            p_dat = dout_dat_o;
            p_lst = dout_lst_o;
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_rdy_i = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_din(input logic [7:0] b, input bit lst);
        int guard = 0;
        din_val_i = 1'b1;
        din_dat_i = b;
        din_lst_i = lst;
        forever begin
            @(negedge clk);
            if (din_rdy_o) break;
            guard++;
            if (guard > 2000) begin
                fail_now("din_accept_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        din_val_i = 1'b0;
        din_lst_i = 1'b0;
        din_dat_i = 8'($urandom);
    endtask

    task automatic pulse_adl(input logic [31:0] v);
        adl_val_i = 1'b1;
        adl_dat_i = v;
        @(posedge clk); #1;
        adl_val_i = 1'b0;
        adl_dat_i = $urandom;
    endtask

    // late=0: Adler pulsed after the first deflate byte; late=1: pulsed
    // 5 cycles after the last deflate byte is taken.
    task automatic run_frame(input logic [7:0] pay[$], input logic [31:0] adl,
                             input bit late, input bit spurious, input int max_gap);
        int guard = 0;
        model_frame(pay, adl);
        frame_open = 1'b1;
        last_din_taken = 1'b0;
        out_cnt = 0;
        log_q.delete();
        log_cyc.delete();
        pulse_start();
        for (int i = 0; i < pay.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk); #1;
            end
            send_din(pay[i], i == pay.size() - 1);
            if (i == 0 && !late) pulse_adl(adl);
            if (i == 0 && spurious && pay.size() > 1) begin
                start_i = 1'b1;
                pulse_adl(~adl);
                start_i = 1'b0;
            end
        end
        if (spurious) begin
            @(posedge clk); #1;
            pulse_start();
            pulse_adl(adl ^ 32'h5A5A_5A5A);
        end
        if (late) begin
            repeat (4) begin
                @(posedge clk); #1;
            end
            adl_cyc = cyc;
            pulse_adl(adl);
        end
        forever begin
            @(negedge clk);
            if (done_o) break;
            guard++;
            if (guard > 5000) begin
                fail_now("done_timeout");
                break;
            end
        end
        check("frame_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_log(input string nm, input logic [7:0] lit[8]);
        check({nm, "_len"}, log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) check(nm, log_q[i], lit[i]);
    endtask

    // ---------------- test sequence ----------------
    logic [7:0] pay[$];
    logic [7:0] lit_basic[8] = '{8'h78, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] lit_late[8]  = '{8'h78, 8'h01, 8'h03, 8'h00, 8'h02, 8'h4D, 8'h01, 8'h27};

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Model pinned against a hand-written stream.
        pay = '{8'h03, 8'h00};
        model_frame(pay, 32'h0000_0001);
        check("model_len", exp_q.size(), 8);
        for (int i = 0; i < 8 && i < exp_q.size(); i++) check("model_byte", exp_q[i][7:0], lit_basic[i]);
        check("model_lst", exp_q[exp_q.size() - 1][8], 1);
        exp_q.delete();

        // Basic frame, continuous ready.
        rdy_pct = 100;
        run_frame(pay, 32'h0000_0001, 1'b0, 1'b0, 0);
        check_log("basic", lit_basic);

        // Late Adler, started the cycle after done_o (latch must be re-armed).
        run_frame(pay, 32'h024D_0127, 1'b1, 1'b0, 0);
        check_log("late", lit_late);
        if (log_cyc.size() == 8) begin
            check("late_trl_latency", log_cyc[4], adl_cyc + 2);
            for (int k = 5; k < 8; k++) check("late_trl_gap", log_cyc[k], log_cyc[k - 1] + 1);
        end

        // Backpressure with a 100-byte payload, both Adler timings.
        rdy_pct = 50;
        for (int f = 0; f < 2; f++) begin
            pay.delete();
            for (int i = 0; i < 100; i++) pay.push_back(8'($urandom));
            run_frame(pay, $urandom, f[0], 1'b0, 2);
            check("bp_out_count", out_cnt, 106);
        end

        // Spurious start/Adler during DATA and TRL.
        rdy_pct = 70;
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
        run_frame(pay, 32'hCAFE_F00D, 1'b0, 1'b1, 1);

        // Reset while the HDR1 byte is being produced.
        rdy_pct = 100;
        pulse_start();
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
        run_frame(pay, 32'h1234_5678, 1'b1, 1'b0, 0);
        if (log_q.size() >= 2) begin
            check("post_rst_cmf", log_q[0], 8'h78);
            check("post_rst_flg", log_q[1], 8'h01);
        end

        // Random back-to-back frames.
        for (int f = 0; f < 6; f++) begin
            rdy_pct = $urandom_range(30, 100);
            pay.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) pay.push_back(8'($urandom));
            run_frame(pay, $urandom, 1'($urandom), 1'b0, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
